ins_stream: RTL and testbench

INS_STREAM -- requirements
Module: ins_stream

---
 rtl/ins_stream.sv | 99 +++++++++
 tb/tb_ins_stream.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ins_stream.sv
// ins_stream: serial-in/serial-out insertion sorter.
// Words are inserted into a sorted slot array as they arrive (FILL), then
// streamed out from slot 0 (DRAIN). Compile-time option INS_STREAM_DESCEND_EN
// selects descending order; default build sorts ascending.
module ins_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

`ifdef INS_STREAM_DESCEND_EN
  localparam bit DESCEND = 1'b1;
`else
  localparam bit DESCEND = 1'b0;
`endif

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] slot     [DEPTH];
  logic [WIDTH-1:0] ins_slot [DEPTH];
  logic [DEPTH-1:0] stay;
  logic             in_xfer, out_xfer;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    in_xfer   = 1'b0;
    out_xfer  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        in_xfer  = in_valid;
        if (in_valid && (in_last || count == CW'(DEPTH-1)))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = slot[0];
        out_last  = (count == CW'(1));
        out_xfer  = out_ready;
        if (out_ready && count == CW'(1))
          state_nxt = FILL;
      end
    endcase
  end

  // Insertion network: stay[] marks the sorted prefix of occupied slots that
  // precede the new word (ties stay put, so equal words keep arrival order);
  // the first non-staying slot takes in_data and everything above shifts up.
  always_comb begin
    stay = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      stay[i] = (CW'(i) < count) &&
                (DESCEND ? (slot[i] >= in_data) : (slot[i] <= in_data));
    ins_slot[0] = stay[0] ? slot[0] : in_data;
    for (int unsigned i = 1; i < DEPTH; i++)
      ins_slot[i] = stay[i] ? slot[i] : (stay[i-1] ? in_data : slot[i-1]);
  end

  // Slot array and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) slot[i] <= '0;
      count <= '0;
    end else if (in_xfer) begin
      for (int unsigned i = 0; i < DEPTH; i++) slot[i] <= ins_slot[i];
      count <= count + CW'(1);
    end else if (out_xfer) begin
      for (int unsigned i = 0; i < DEPTH-1; i++) slot[i] <= slot[i+1];
      slot[DEPTH-1] <= '0;
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_ins_stream.sv
// Scoreboard bench for ins_stream: stimulus pushes expected outputs into a
// queue, a negedge monitor pops and compares on every output transfer.
module tb_ins_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [3:0]  count;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [32:0] exp_q[$];
  logic [31:0] din  [8];
  logic [31:0] expv [8];
  bit          pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  ins_stream #(.WIDTH(32), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each output transfer against the scoreboard
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) check("in_ready_drain", {31'd0, in_ready}, 32'd0);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[31:0]);
          check("out_last", {31'd0, out_last}, {31'd0, e[32]});
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    check("in_ready_fill", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_batch(input int n, input bit use_last);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n-1), expv[i]});
    for (int i = 0; i < n; i++) send(din[i], use_last && (i == n-1));
  endtask

  task automatic wait_drain(input bit bp);
    int k = 1;
    int cyc = 0;
    while (exp_q.size() != 0 || out_valid) begin
      if (!bp && exp_q.size() != 0) check("no_gap", {31'd0, out_valid}, 32'd1);
      if (cyc >= 100) begin
        n_checks++;
        n_err++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        exp_q.delete();
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (bp) begin
        out_ready = pat[k % 4];
        k++;
      end
    end
    out_ready = 1'b1;
    check("count_after_drain", {28'd0, count}, 32'd0);
    check("in_ready_after_drain", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count",     {28'd0, count},     32'd0);
    check("rst_out_data",  out_data,           32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Full batch, count reaches DEPTH without in_last
    din = '{5, 3, 8, 1, 9, 2, 7, 4};
`ifdef INS_STREAM_DESCEND_EN
    expv = '{9, 8, 7, 5, 4, 3, 2, 1};
`else
    expv = '{1, 2, 3, 4, 5, 7, 8, 9};
`endif
    run_batch(8, 1'b0);
    check("full_latency", {31'd0, out_valid}, 32'd1);
    check("full_count",   {28'd0, count},     32'd8);
    wait_drain(1'b0);

    // Short batch, unsigned ordering
    din = '{32'hFFFF_FFFF, 32'h0, 32'h10, 0, 0, 0, 0, 0};
`ifdef INS_STREAM_DESCEND_EN
    expv = '{32'hFFFF_FFFF, 32'h10, 32'h0, 0, 0, 0, 0, 0};
`else
    expv = '{32'h0, 32'h10, 32'hFFFF_FFFF, 0, 0, 0, 0, 0};
`endif
    run_batch(3, 1'b1);
    check("short_count", {28'd0, count}, 32'd3);
    wait_drain(1'b0);

    // Backpressure on the full batch
    din = '{5, 3, 8, 1, 9, 2, 7, 4};
`ifdef INS_STREAM_DESCEND_EN
    expv = '{9, 8, 7, 5, 4, 3, 2, 1};
`else
    expv = '{1, 2, 3, 4, 5, 7, 8, 9};
`endif
    run_batch(8, 1'b0);
    wait_drain(1'b1);

    // Duplicates, then a single-word batch
    din  = '{6, 6, 6, 0, 0, 0, 0, 0};
    expv = '{6, 6, 6, 0, 0, 0, 0, 0};
    run_batch(3, 1'b1);
    wait_drain(1'b0);
    din  = '{42, 0, 0, 0, 0, 0, 0, 0};
    expv = '{42, 0, 0, 0, 0, 0, 0, 0};
    run_batch(1, 1'b1);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_last",  {31'd0, out_last},  32'd1);
    wait_drain(1'b0);

    // Reset after four outputs of a full batch
    din = '{5, 3, 8, 1, 9, 2, 7, 4};
`ifdef INS_STREAM_DESCEND_EN
    expv = '{9, 8, 7, 5, 4, 3, 2, 1};
`else
    expv = '{1, 2, 3, 4, 5, 7, 8, 9};
`endif
    run_batch(8, 1'b0);
    cyc = 0;
    while (exp_q.size() > 4 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("pre_reset_pending", exp_q.size(), 32'd4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count",     {28'd0, count},     32'd0);
    check("mid_rst_out_data",  out_data,           32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_mid_rst", {31'd0, in_ready}, 32'd1);
    din = '{2, 1, 0, 0, 0, 0, 0, 0};
`ifdef INS_STREAM_DESCEND_EN
    expv = '{2, 1, 0, 0, 0, 0, 0, 0};
`else
    expv = '{1, 2, 0, 0, 0, 0, 0, 0};
`endif
    run_batch(2, 1'b1);
    wait_drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
